ball_collision_detect: RTL and testbench

- Upstream of the ball motion stage; produces its `collision`, `X_direction`, `Y_direction` and `goal` inputs.
- Watches per-pixel drawing requests during the VGA raster: ball, player rods, goal mouths.
- Accumulates overlaps over one frame and commits one report per frame at start of frame.
- Applies per-event hold-off so a single touch yields exactly one collision or goal event.

---
 rtl/ball_collision_detect.sv | 82 ++++++++
 tb/tb_ball_collision_detect.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ball_collision_detect.sv
// ball_collision_detect: per-frame ball/player/goal overlap detection with hold-off, committed at start of frame
module ball_collision_detect #(
  parameter int PLAYER_H     = 64,
  parameter int COLL_HOLDOFF = 4,
  parameter int GOAL_HOLDOFF = 60,
  parameter int SCREEN_MID_X = 320
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic        ballDR,
  input  logic        playerDR,
  input  logic [6:0]  playerOffsetY,
  input  logic        goalDR,
  input  logic        move,
  output logic        collision,
  output logic        X_direction,
  output logic        Y_direction,
  output logic        goal,
  output logic        goal_side
);
  localparam logic [6:0] T1 = 7'(PLAYER_H / 3);
  localparam logic [6:0] T2 = 7'(2 * PLAYER_H / 3);
  localparam int CW = $clog2((COLL_HOLDOFF > GOAL_HOLDOFF ? COLL_HOLDOFF : GOAL_HOLDOFF) + 1);
  logic hit_p, hit_g, side, zx, zy;
  logic [CW-1:0] coll_cnt, goal_cnt;
  logic p_now, g_now, nx, ny, pix_side, goal_ok, coll_ok;
  // flags only accumulate while the game runs, so a move=0 frame can never be reported later
  assign p_now    = move && ballDR && playerDR;
  assign g_now    = move && ballDR && goalDR;
  assign nx       = playerOffsetY >= T2;
  assign ny       = playerOffsetY < T1 || playerOffsetY >= T2;
  assign pix_side = pixelX >= 11'(SCREEN_MID_X);
  assign goal_ok  = hit_g && goal_cnt == '0;
  assign coll_ok  = hit_p && !hit_g && goal_cnt == '0 && coll_cnt == '0;
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      collision   <= 1'b0;
      goal        <= 1'b0;
      X_direction <= 1'b0;
      Y_direction <= 1'b0;
      goal_side   <= 1'b0;
      hit_p       <= 1'b0;
      hit_g       <= 1'b0;
      side        <= 1'b0;
      zx          <= 1'b0;
      zy          <= 1'b0;
      coll_cnt    <= '0;
      goal_cnt    <= '0;
    end else begin
      collision <= 1'b0;
      goal      <= 1'b0;
      if (startOfFrame) begin
        if (!move) begin
          coll_cnt <= '0;
          goal_cnt <= '0;
        end else begin
          goal      <= goal_ok;
          collision <= coll_ok;
          if (goal_ok) goal_side <= side;
          if (coll_ok) begin
            X_direction <= zx;
            Y_direction <= zy;
          end
          goal_cnt <= goal_ok ? CW'(GOAL_HOLDOFF) : (goal_cnt != '0 ? goal_cnt - 1'b1 : goal_cnt);
          coll_cnt <= coll_ok ? CW'(COLL_HOLDOFF) : (coll_cnt != '0 ? coll_cnt - 1'b1 : coll_cnt);
        end
      end
      // first overlap of the frame wins; the start-of-frame pixel opens the new frame
      if (startOfFrame || !hit_p) begin
        hit_p <= p_now;
        zx    <= nx;
        zy    <= ny;
      end
      if (startOfFrame || !hit_g) begin
        hit_g <= g_now;
        side  <= pix_side;
      end
    end
  end
endmodule

// File: tb/tb_ball_collision_detect.sv
// tb_ball_collision_detect: directed frames with a pulse scoreboard for ball_collision_detect
module tb_ball_collision_detect;
  logic CLK = 1'b0, RESETn, startOfFrame, ballDR, playerDR, goalDR, move;
  logic [10:0] pixelX;
  logic [6:0] playerOffsetY;
  logic collision, X_direction, Y_direction, goal, goal_side;
  typedef struct {
    bit g;
    bit x;
    bit y;
    bit s;
    int f;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, fno = 0;

  ball_collision_detect dut (
    .CLK(CLK), .RESETn(RESETn), .startOfFrame(startOfFrame), .pixelX(pixelX),
    .ballDR(ballDR), .playerDR(playerDR), .playerOffsetY(playerOffsetY),
    .goalDR(goalDR), .move(move), .collision(collision), .X_direction(X_direction),
    .Y_direction(Y_direction), .goal(goal), .goal_side(goal_side)
  );

  always #5 CLK = ~CLK;

  // pulses show up one cycle after the start of the frame following the data frame
  task automatic expect_ev(input bit g, input bit x, input bit y, input bit s);
    q.push_back('{g, x, y, s, fno + 2});
  endtask

  task automatic chk(input string n, input logic a, input logic e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %b expected %b", n, a, e);
    end
  endtask

  task automatic frame(input bit hp, input int off, input int n, input bit hg, input int px, input int len);
    fno++;
    for (int c = 0; c < len; c++) begin
      @(posedge CLK); #1;
      startOfFrame = (c == 0);
      ballDR = 0; playerDR = 0; goalDR = 0; playerOffsetY = 0;
      pixelX = 11'(c * 40);
      if (hp && c >= 2 && c < 2 + n) begin
        ballDR = 1; playerDR = 1; playerOffsetY = 7'(off + c - 2);
      end
      if (hg && c == 12) begin
        ballDR = 1; goalDR = 1; pixelX = 11'(px);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) frame(0, 0, 0, 0, 0, 16);
  endtask

  always @(negedge CLK) begin
    if (RESETn === 1'b1 && (collision || goal)) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: coll=%b goal=%b frame=%0d expected none", collision, goal, fno);
      end else begin
        exp_t e;
        bit ok;
        e = q.pop_front();
        ok = (goal == e.g) && (collision != goal) && (fno == e.f) &&
             (e.g ? goal_side == e.s : (X_direction == e.x && Y_direction == e.y));
        if (!ok) begin
          fails++;
          $display("FAIL pulse: got goal=%b coll=%b X=%b Y=%b side=%b frame=%0d expected goal=%b X=%b Y=%b side=%b frame=%0d",
                   goal, collision, X_direction, Y_direction, goal_side, fno, e.g, e.x, e.y, e.s, e.f);
        end
      end
    end
  end

  initial begin
    RESETn = 0; move = 0; startOfFrame = 0; ballDR = 0; playerDR = 0; goalDR = 0;
    pixelX = 0; playerOffsetY = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_collision", collision, 0);
    chk("rst_goal", goal, 0);
    chk("rst_x", X_direction, 0);
    chk("rst_y", Y_direction, 0);
    chk("rst_side", goal_side, 0);
    RESETn = 1; move = 1;
    idle(2);
    expect_ev(0, 0, 1, 0);
    frame(1, 5, 8, 0, 0, 16);
    idle(5);
    expect_ev(0, 0, 0, 0);
    repeat (4) frame(1, 30, 1, 0, 0, 16);
    idle(1);
    expect_ev(0, 0, 0, 0);
    frame(1, 30, 1, 0, 0, 16);
    idle(5);
    chk("mid_x", X_direction, 0);
    chk("mid_y", Y_direction, 0);
    expect_ev(0, 1, 1, 0);
    frame(1, 50, 1, 0, 0, 16);
    frame(1, 10, 1, 0, 0, 16);
    idle(5);
    chk("holdoff_x", X_direction, 1);
    chk("holdoff_y", Y_direction, 1);
    expect_ev(0, 0, 0, 0);
    frame(1, 40, 6, 0, 0, 16);
    idle(5);
    expect_ev(1, 0, 0, 1);
    frame(1, 30, 1, 1, 600, 16);
    for (int k = 1; k <= 61; k++) begin
      if (k == 61) expect_ev(0, 0, 1, 0);
      frame(1, 10, 1, 0, 0, 16);
    end
    chk("side_right", goal_side, 1);
    idle(5);
    expect_ev(1, 0, 0, 0);
    frame(0, 0, 0, 1, 10, 16);
    idle(1);
    chk("side_left", goal_side, 0);
    move = 0;
    frame(1, 30, 1, 1, 10, 16);
    idle(1);
    move = 1;
    idle(1);
    expect_ev(0, 1, 1, 0);
    frame(1, 50, 1, 0, 0, 16);
    frame(1, 20, 3, 0, 0, 8);
    @(posedge CLK); #1;
    RESETn = 0; startOfFrame = 0; ballDR = 0; playerDR = 0; goalDR = 0;
    #1;
    chk("async_collision", collision, 0);
    chk("async_goal", goal, 0);
    chk("async_x", X_direction, 0);
    chk("async_y", Y_direction, 0);
    chk("async_side", goal_side, 0);
    @(posedge CLK); #1;
    RESETn = 1;
    idle(3);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_pulses: got %0d outstanding expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
